rsa_encrypt: RTL and testbench
==============================

RSA_ENCRYPT -- requirements
Module: rsa_encrypt

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 m  input  32  plaintext, unsigned.
REQ-006 e  input  32  public exponent, unsigned.
REQ-007 n  input  32  modulus, unsigned.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when c/err are valid.
REQ-010 c  output  32  ciphertext = m^e mod n.
REQ-011 err  output  1  invalid modulus flag (n < 2), valid with done.

Function
REQ-012 The block SHALL latch m, e and n on the rising edge where start=1 in IDLE; later input changes SHALL NOT affect the operation.
REQ-013 States SHALL be IDLE, LOAD, EXP and DONE, with IDLE->LOAD on accepted start.
REQ-014 A latched n of 0 or 1 SHALL go IDLE->DONE directly with err=1 and c=0.
REQ-015 LOAD SHALL reduce base = m mod n by 32-cycle restoring division, one dividend bit per cycle, MSB first.
REQ-016 EXP SHALL run right-to-left square-and-multiply over all 32 bits of e, LSB first, with result initialised to 1.
REQ-017 Each exponent bit SHALL take exactly 32 cycles, regardless of e value (constant time).
REQ-018 Within each bit, two interleaved shift-add modular multipliers SHALL run in parallel: result*base (committed only if the e bit is 1) and base*base (always committed).
REQ-019 Each multiplier iteration SHALL compute acc = (2*acc [+ a]) mod n using at most two conditional subtractions.
REQ-020 Intermediates SHALL be 34 bits wide so that n up to 0xFFFFFFFF never overflows.
REQ-021 After the last bit, EXP->DONE; DONE SHALL assert done=1 for exactly one cycle, drive c=result and err=0, then return to IDLE.
REQ-022 For valid n, done SHALL be high on the edge exactly 1057 cycles after the start-sampling edge (1 + 32 LOAD + 1024 EXP).
REQ-023 For invalid n, done SHALL be high on the edge exactly 1 cycle after the start-sampling edge.
REQ-024 c and err SHALL hold their values from done until the next done.
REQ-025 Start while busy=1 SHALL be ignored, with no queuing.
REQ-026 Start on the same edge as done SHALL be ignored; the next start SHALL be accepted from IDLE.
REQ-027 e=0 SHALL give c=1, and m mod n = 0 with e != 0 SHALL give c=0.
REQ-028 m >= n SHALL give the same result as m mod n.

Reset
REQ-029 When rst_n=0, the block SHALL asynchronously force state=IDLE and busy=0, done=0, c=0, err=0, and clear all datapath registers.
REQ-030 Reset mid-operation SHALL abort the operation with no done pulse; a start after reset release SHALL run a full, correct operation.

Verification
REQ-031 m=65, e=17, n=3233, start -> done at +1057 cycles, c=2790 (0x00000AE6), err=0.
REQ-032 m=3298, e=17, n=3233 -> c=2790; m=0xFFFFFFFF, e=1, n=0xFFFFFFFB -> c=4.
REQ-033 m=12345, e=0, n=3233 -> c=1; m=0, e=5, n=3233 -> c=0; both have a 1057-cycle latency.
REQ-034 n=1 (and separately n=0), any m and e -> done at +1 cycle, err=1, c=0.
REQ-035 Assert start again at +10 and +500 cycles while busy -> exactly one done pulse, with c computed from the first latched operands.
REQ-036 Drop rst_n at +600 cycles -> busy, done and c go to 0 immediately, with no done pulse; release rst_n, start m=65, e=17, n=3233 -> c=2790.

Source files
------------

// File: rtl/rsa_encrypt.sv
// 32-bit modular exponentiation c = m^e mod n: restoring division for m mod n, then
// constant-time right-to-left square-and-multiply using two parallel shift-add multipliers.
module rsa_encrypt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] m,
    input  logic [31:0] e,
    input  logic [31:0] n,
    output logic        busy,
    output logic        done,
    output logic [31:0] c,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StLoad, StExp, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] m_q, e_q, c_q;
    logic [33:0] n_q, rem_q, base_q, result_q, acc_r_q, acc_b_q;
    logic [4:0]  cnt_q, bit_q;
    logic        err_q;

    logic [33:0] rem_shift, rem_next, acc_r_next, acc_b_next;
    logic        mul_bit;

    // acc < n, so 2*acc + add < 3n: two conditional subtractions always suffice.
    function automatic logic [33:0] mod_step(input logic [33:0] acc, input logic [33:0] add,
                                             input logic [33:0] modulus);
        logic [33:0] t;
        t = (acc << 1) + add;
        if (t >= modulus) t = t - modulus;
        if (t >= modulus) t = t - modulus;
        return t;
    endfunction

    always_comb begin
        rem_shift  = (rem_q << 1) | {33'b0, m_q[31]};
        rem_next   = (rem_shift >= n_q) ? rem_shift - n_q : rem_shift;
        mul_bit    = base_q[5'd31 - cnt_q];
        acc_r_next = mod_step(acc_r_q, mul_bit ? result_q : 34'd0, n_q);
        acc_b_next = mod_step(acc_b_q, mul_bit ? base_q : 34'd0, n_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = (n[31:1] == 31'd0) ? StDone : StLoad;
            StLoad: if (cnt_q == 5'd31) state_d = StExp;
            StExp:  if (cnt_q == 5'd31 && bit_q == 5'd31) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q      <= '0;
            e_q      <= '0;
            n_q      <= '0;
            rem_q    <= '0;
            base_q   <= '0;
            result_q <= '0;
            acc_r_q  <= '0;
            acc_b_q  <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            c_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        m_q   <= m;
                        e_q   <= e;
                        n_q   <= {2'b00, n};
                        rem_q <= '0;
                        cnt_q <= '0;
                        bit_q <= '0;
                        if (n[31:1] == 31'd0) begin
                            c_q   <= '0;
                            err_q <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    rem_q <= rem_next;
                    m_q   <= m_q << 1;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        base_q   <= rem_next;
                        result_q <= 34'd1;
                        acc_r_q  <= '0;
                        acc_b_q  <= '0;
                    end
                end
                StExp: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        // Both products are complete: commit and start the next exponent bit.
                        if (e_q[0]) result_q <= acc_r_next;
                        base_q  <= acc_b_next;
                        e_q     <= e_q >> 1;
                        bit_q   <= bit_q + 5'd1;
                        acc_r_q <= '0;
                        acc_b_q <= '0;
                        if (bit_q == 5'd31) begin
                            c_q   <= e_q[0] ? acc_r_next[31:0] : result_q[31:0];
                            err_q <= 1'b0;
                        end
                    end else begin
                        acc_r_q <= acc_r_next;
                        acc_b_q <= acc_b_next;
                    end
                end
                StDone: ;
                default: ;
            endcase
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign c    = c_q;
    assign err  = err_q;

endmodule

// File: tb/tb_rsa_encrypt.sv
// Scoreboard bench for rsa_encrypt: stimulus pushes expected results, a negedge monitor
// pops and compares value, error flag and latency on every done pulse.
module tb_rsa_encrypt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] m = '0, e = '0, n = '0;
    logic        busy, done, err;
    logic [31:0] c;

    rsa_encrypt dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .m    (m),
        .e    (e),
        .n    (n),
        .busy (busy),
        .done (done),
        .c    (c),
        .err  (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] c;
        logic        err;
        int          lat;
        int          start_edge;
    } exp_t;

    typedef struct {
        logic [31:0] m;
        logic [31:0] e;
        logic [31:0] n;
        logic [31:0] c;
        logic        err;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: done seen at this negedge is sampled on posedge cyc+1.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t x;
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got a done pulse expected none (cycle %0d)", cyc);
            end else begin
                x = sb.pop_front();
                check("c", c, x.c);
                check("err", 32'(err), 32'(x.err));
                check("latency", 32'(cyc + 1 - x.start_edge), 32'(x.lat));
            end
        end
    end

    task automatic issue(input logic [31:0] mm, input logic [31:0] ee, input logic [31:0] nn,
                         input logic [31:0] cc, input logic er);
        exp_t x;
        @(negedge clk);
        m = mm;
        e = ee;
        n = nn;
        x.c = cc;
        x.err = er;
        x.lat = (nn < 32'd2) ? 1 : 1057;
        x.start_edge = cyc + 1;
        sb.push_back(x);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Operands must already be latched; scramble them.
        m = $urandom;
        e = $urandom;
        n = $urandom;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done();
        int base;
        base = done_cnt;
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt != base) break;
            @(negedge clk);
            #1;
        end
        if (done_cnt == base) begin
            checks++;
            fails++;
            $display("FAIL timeout: got no done within 3000 cycles expected a done pulse");
            if (sb.size() != 0) void'(sb.pop_front());
        end
    endtask

    vec_t vecs[11] = '{
        '{32'd65,         32'd17, 32'd3233,       32'd2790, 1'b0},
        '{32'd3298,       32'd17, 32'd3233,       32'd2790, 1'b0},
        '{32'hFFFFFFFF,   32'd1,  32'hFFFFFFFB,   32'd4,    1'b0},
        '{32'd12345,      32'd0,  32'd3233,       32'd1,    1'b0},
        '{32'd0,          32'd5,  32'd3233,       32'd0,    1'b0},
        '{32'd3,          32'd5,  32'd7,          32'd5,    1'b0},
        '{32'd2,          32'd10, 32'd1000,       32'd24,   1'b0},
        '{32'd2,          32'd32, 32'hFFFFFFFF,   32'd1,    1'b0},
        '{32'hFFFFFFFE,   32'd2,  32'hFFFFFFFF,   32'd1,    1'b0},
        '{32'd7,          32'd9,  32'd1,          32'd0,    1'b1},
        '{32'd7,          32'd9,  32'd0,          32'd0,    1'b1}
    };

    initial begin
        int snap;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_c", c, 32'd0);
        check("reset_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].m, vecs[i].e, vecs[i].n, vecs[i].c, vecs[i].err);
            wait_done();
            repeat (3) @(negedge clk);
            check("idle_after_done", 32'(busy), 32'd0);
            check("c_hold", c, vecs[i].c);
        end

        // Start coinciding with done is dropped.
        issue(32'd65, 32'd17, 32'd3233, 32'd2790, 1'b0);
        wait_done();
        m = 32'd7;
        e = 32'd3;
        n = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        snap = done_cnt;
        check("start_on_done_ignored", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check("no_extra_done", 32'(done_cnt - snap), 32'd0);
        issue(32'd3, 32'd5, 32'd7, 32'd5, 1'b0);
        wait_done();

        // Starts while busy are neither accepted nor queued.
        snap = done_cnt;
        issue(32'd65, 32'd17, 32'd3233, 32'd2790, 1'b0);
        repeat (8) @(negedge clk);
        m = 32'd5; e = 32'd3; n = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (489) @(negedge clk);
        m = 32'd2; e = 32'd10; n = 32'd1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (1100) @(negedge clk);
        check("single_done_while_busy", 32'(done_cnt - snap), 32'd1);

        // Asynchronous reset mid-operation aborts without a done pulse.
        issue(32'd65, 32'd17, 32'd3233, 32'd2790, 1'b0);
        repeat (599) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_c", c, 32'd0);
        check("abort_err", 32'(err), 32'd0);
        if (sb.size() != 0) void'(sb.pop_front());
        snap = done_cnt;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (1100) @(negedge clk);
        check("no_done_after_abort", 32'(done_cnt - snap), 32'd0);
        issue(32'd65, 32'd17, 32'd3233, 32'd2790, 1'b0);
        wait_done();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
